instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 90 +++++++++
 tb/tb_instruction_fetch.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: sequential PC fetch from a fixed one-cycle-latency memory,
// a 2-entry response FIFO toward decode, and redirect handling that kills in-flight words.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [63:0] if_pc
);

  logic [63:0] pc;
  logic [63:0] req_pc;
  logic        inflight;
  logic        started;

  logic [31:0] fifo_instr [2];
  logic [63:0] fifo_pc    [2];
  logic        head;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        wr_idx;
  logic [1:0]  count_after_pop;
  logic [1:0]  occupancy;

  // A response still in flight reserves a FIFO slot, so the FIFO can never overflow.
  always_comb begin
    pop             = (count != 2'd0) && if_ready && !redirect_valid;
    push            = inflight && !redirect_valid;
    count_after_pop = count - {1'b0, pop};
    occupancy       = count_after_pop + {1'b0, inflight};
    wr_idx          = head ^ count[0];
    imem_req        = started && !redirect_valid && (occupancy < 2'd2);
    imem_addr       = imem_req ? pc : 64'h0;
  end

  assign if_valid       = (count != 2'd0);
  assign if_instruction = if_valid ? fifo_instr[head] : 32'h0;
  assign if_pc          = if_valid ? fifo_pc[head]    : 64'h0;

  // A redirect flushes the FIFO and drops the response arriving this cycle by never pushing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_pc   <= 64'h0;
      inflight <= 1'b0;
      started  <= 1'b0;
      head     <= 1'b0;
      count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr[i] <= 32'h0;
        fifo_pc[i]    <= 64'h0;
      end
    end else begin
      started <= 1'b1;
      if (redirect_valid) begin
        pc       <= redirect_pc & ~64'h3;
        inflight <= 1'b0;
        head     <= 1'b0;
        count    <= 2'd0;
      end else begin
        if (imem_req) begin
          pc       <= pc + 64'd4;
          req_pc   <= pc;
          inflight <= 1'b1;
        end else begin
          inflight <= 1'b0;
        end
        if (push) begin
          fifo_instr[wr_idx] <= imem_rdata;
          fifo_pc[wr_idx]    <= req_pc;
        end
        if (pop) begin
          head <= ~head;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a one-cycle memory model plus a scoreboard
// of expected {instruction, pc} entries, and scenario tasks with their own checks.
module tb_instruction_fetch;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instruction;
  logic [63:0] if_pc;

  int tests_run = 0;
  int tests_failed = 0;
  bit nop_mode = 1'b0;

  logic [63:0] exp_pc_q  [$];
  logic [31:0] exp_ins_q [$];
  bit          mon_inflight = 1'b0;
  logic [63:0] model_pc = RESET_PC;
  int          fifo_cnt;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instruction (if_instruction),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return nop_mode ? 32'h0000_0013 : (a[31:0] ^ 32'hC0DE_0003);
  endfunction

  // Memory: every request accepted, word returned during the following cycle only.
  always @(posedge clk) begin
    if (imem_req === 1'b1) imem_rdata <= mem_word(imem_addr);
    else                   imem_rdata <= 32'hDEAD_BEEF;
  end

  // Scoreboard: queue holds buffered entries followed by the in-flight one, if any.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc_q.delete();
      exp_ins_q.delete();
      mon_inflight = 1'b0;
      model_pc = RESET_PC;
    end else begin
      fifo_cnt = exp_pc_q.size() - (mon_inflight ? 1 : 0);
      tests_run++;
      if (if_valid !== (fifo_cnt > 0)) begin
        tests_failed++;
        $display("[TB] FAIL sb_valid: got %b expected %b", if_valid, (fifo_cnt > 0));
      end
      if (if_valid === 1'b1 && fifo_cnt > 0) begin
        tests_run++;
        if (if_pc !== exp_pc_q[0] || if_instruction !== exp_ins_q[0]) begin
          tests_failed++;
          $display("[TB] FAIL sb_head: got pc=%h ins=%h expected pc=%h ins=%h",
                   if_pc, if_instruction, exp_pc_q[0], exp_ins_q[0]);
        end
        if (if_ready === 1'b1 && redirect_valid !== 1'b1) begin
          void'(exp_pc_q.pop_front());
          void'(exp_ins_q.pop_front());
        end
      end
      if (imem_req === 1'b1) begin
        tests_run++;
        if (redirect_valid === 1'b1 || exp_pc_q.size() >= 2 || imem_addr !== model_pc) begin
          tests_failed++;
          $display("[TB] FAIL sb_req: got addr=%h occ=%0d redir=%b expected addr=%h occ<2 redir=0",
                   imem_addr, exp_pc_q.size(), redirect_valid, model_pc);
        end
        exp_pc_q.push_back(model_pc);
        exp_ins_q.push_back(mem_word(model_pc));
        model_pc = model_pc + 64'd4;
        mon_inflight = 1'b1;
      end else begin
        mon_inflight = 1'b0;
      end
      if (redirect_valid === 1'b1) begin
        exp_pc_q.delete();
        exp_ins_q.delete();
        mon_inflight = 1'b0;
        model_pc = redirect_pc & ~64'h3;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_release(input logic ready);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    if_ready = ready;
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    nop_mode = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0 || imem_addr !== 64'h0 || if_valid !== 1'b0 ||
        if_instruction !== 32'h0 || if_pc !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got req=%b addr=%h valid=%b ins=%h pc=%h expected all zero",
               imem_req, imem_addr, if_valid, if_instruction, if_pc);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL release_cycle_req: got %b expected 0", imem_req);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      tests_failed++;
      $display("[TB] FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_streaming();
    nop_mode = 1'b1;
    reset_and_release(1'b1);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      tests_run++;
      if (imem_req !== (k >= 1) || (k >= 1 && imem_addr !== 64'(4 * (k - 1)))) begin
        tests_failed++;
        $display("[TB] FAIL stream_req[%0d]: got req=%b addr=%h expected req=%b addr=%h",
                 k, imem_req, imem_addr, (k >= 1), 64'(4 * (k - 1)));
      end
      tests_run++;
      if (if_valid !== (k >= 3) ||
          (k >= 3 && (if_pc !== 64'(4 * (k - 3)) || if_instruction !== 32'h13))) begin
        tests_failed++;
        $display("[TB] FAIL stream_out[%0d]: got valid=%b pc=%h ins=%h expected valid=%b pc=%h ins=00000013",
                 k, if_valid, if_pc, if_instruction, (k >= 3), 64'(4 * (k - 3)));
      end
    end
  endtask

  task automatic test_backpressure();
    int reqs = 0;
    nop_mode = 1'b0;
    reset_and_release(1'b0);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      if (imem_req === 1'b1) reqs++;
      if (k >= 3) begin
        tests_run++;
        if (if_valid !== 1'b1 || if_pc !== 64'h0) begin
          tests_failed++;
          $display("[TB] FAIL stall_hold[%0d]: got valid=%b pc=%h expected valid=1 pc=0", k, if_valid, if_pc);
        end
      end
    end
    tests_run++;
    if (reqs != 2) begin
      tests_failed++;
      $display("[TB] FAIL stall_req_count: got %0d expected 2", reqs);
    end
    next_cycle();
    if_ready = 1'b1;
    @(negedge clk);
    for (int k = 9; k <= 11; k++) begin
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (if_valid !== 1'b1 || if_pc !== 64'(4 * (k - 8))) begin
        tests_failed++;
        $display("[TB] FAIL release_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h",
                 k, if_valid, if_pc, 64'(4 * (k - 8)));
      end
    end
  endtask

  task automatic test_redirect_inflight();
    nop_mode = 1'b0;
    reset_and_release(1'b0);
    repeat (3) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL redirect_req: got %b expected 0", imem_req);
    end
    next_cycle();
    redirect_valid = 1'b0;
    if_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h100) begin
      tests_failed++;
      $display("[TB] FAIL redirect_next: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=100",
               if_valid, imem_req, imem_addr);
    end
    repeat (2) next_cycle();
    @(negedge clk);
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 64'h100) begin
      tests_failed++;
      $display("[TB] FAIL redirect_target: got valid=%b pc=%h expected valid=1 pc=100", if_valid, if_pc);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 64'h104) begin
      tests_failed++;
      $display("[TB] FAIL redirect_follow: got valid=%b pc=%h expected valid=1 pc=104", if_valid, if_pc);
    end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 64'h300;
    @(negedge clk);
    next_cycle();
    redirect_pc = 64'h400;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got req=%b valid=%b expected req=0 valid=0", imem_req, if_valid);
    end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h400) begin
      tests_failed++;
      $display("[TB] FAIL b2b_addr: got req=%b addr=%h expected req=1 addr=400", imem_req, imem_addr);
    end
    repeat (2) next_cycle();
    @(negedge clk);
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 64'h400) begin
      tests_failed++;
      $display("[TB] FAIL b2b_target: got valid=%b pc=%h expected valid=1 pc=400", if_valid, if_pc);
    end
  endtask

  task automatic test_misaligned();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 64'h203;
    @(negedge clk);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin
      tests_failed++;
      $display("[TB] FAIL misaligned: got req=%b addr=%h expected req=1 addr=200", imem_req, imem_addr);
    end
    repeat (3) next_cycle();
  endtask

  task automatic test_wrap();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      tests_failed++;
      $display("[TB] FAIL wrap_first: got req=%b addr=%h expected req=1 addr=fffffffffffffffc", imem_req, imem_addr);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_next: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      tests_failed++;
      $display("[TB] FAIL wrap_out: got valid=%b pc=%h expected valid=1 pc=fffffffffffffffc", if_valid, if_pc);
    end
  endtask

  task automatic test_reset_midstream();
    next_cycle();
    if_ready = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    tests_run++;
    if (if_valid !== 1'b1 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_full: got valid=%b req=%b expected valid=1 req=0", if_valid, imem_req);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_pc !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL mid_async: got valid=%b req=%b pc=%h expected valid=0 req=0 pc=0",
               if_valid, imem_req, if_pc);
    end
    repeat (2) next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_release: got req=%b valid=%b expected req=0 valid=0", imem_req, if_valid);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      tests_failed++;
      $display("[TB] FAIL mid_first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
    repeat (2) next_cycle();
    @(negedge clk);
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin
      tests_failed++;
      $display("[TB] FAIL mid_first_out: got valid=%b pc=%h expected valid=1 pc=%h", if_valid, if_pc, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    test_reset_midstream();
    repeat (2) next_cycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    tests_failed++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
